// File: rtl/test_pattern_gen.sv
// Programmable test-pattern generator: count, walking-one, Johnson and (optional) LFSR sequences.
// Define TEST_PATTERN_LFSR_EN to build the LFSR; without it mode 2'b11 runs as a counter.
module test_pattern_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ain,
  input  logic             bin,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             edge_sel,
  input  logic [DIV_W-1:0] div,
  output logic [3:0]       logic_out,
  output logic [WIDTH-1:0] pattern,
  output logic             tick,
  output logic             wrap
);

`ifdef TEST_PATTERN_LFSR_EN
  // Feedback taps as a bit mask: tap n of the polynomial maps to bit n-1.
  function automatic logic [31:0] tap_mask(input int unsigned w);
    case (w)
      4:       tap_mask = 32'h0000000C;
      5:       tap_mask = 32'h00000014;
      6:       tap_mask = 32'h00000030;
      7:       tap_mask = 32'h00000060;
      8:       tap_mask = 32'h000000B8;
      9:       tap_mask = 32'h00000110;
      10:      tap_mask = 32'h00000240;
      11:      tap_mask = 32'h00000500;
      12:      tap_mask = 32'h00000829;
      13:      tap_mask = 32'h0000100D;
      14:      tap_mask = 32'h00002015;
      15:      tap_mask = 32'h00006000;
      16:      tap_mask = 32'h0000D008;
      17:      tap_mask = 32'h00012000;
      18:      tap_mask = 32'h00020400;
      19:      tap_mask = 32'h00040023;
      20:      tap_mask = 32'h00090000;
      21:      tap_mask = 32'h00140000;
      22:      tap_mask = 32'h00300000;
      23:      tap_mask = 32'h00420000;
      24:      tap_mask = 32'h00E10000;
      25:      tap_mask = 32'h01200000;
      26:      tap_mask = 32'h02000023;
      27:      tap_mask = 32'h04000013;
      28:      tap_mask = 32'h09000000;
      29:      tap_mask = 32'h14000000;
      30:      tap_mask = 32'h20000029;
      31:      tap_mask = 32'h48000000;
      32:      tap_mask = 32'h80200003;
      default: tap_mask = 32'h00000000;
    endcase
  endfunction

  localparam logic [WIDTH-1:0] TapMask = WIDTH'(tap_mask(WIDTH));
`endif

  logic             a_s1_q, a_s2_q, a_prev_q;
  logic             b_s1_q, b_s2_q;
  logic [3:0]       lo_q;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0] pat_q, pat_d, pat_next, seed;
  logic [1:0]       mode_q;
  logic             tick_q, tick_d, wrap_q, wrap_d;
  logic             a_rise, presc_hit, mode_chg, step;

  always_comb begin
    seed = '0;
    unique case (mode)
      2'b01:   seed = WIDTH'(1);
`ifdef TEST_PATTERN_LFSR_EN
      2'b11:   seed = WIDTH'(1);
`else
      2'b11:   seed = '0;
`endif
      default: seed = '0;
    endcase
  end

  always_comb begin
    pat_next = pat_q + WIDTH'(1);
    unique case (mode)
      2'b01:   pat_next = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
      2'b10:   pat_next = {pat_q[WIDTH-2:0], ~pat_q[WIDTH-1]};
`ifdef TEST_PATTERN_LFSR_EN
      2'b11:   pat_next = {pat_q[WIDTH-2:0], ^(pat_q & TapMask)};
`else
      2'b11:   pat_next = pat_q + WIDTH'(1);
`endif
      default: pat_next = pat_q + WIDTH'(1);
    endcase
  end

  // A mode change reloads the seed and swallows any coincident step.
  always_comb begin
    a_rise    = a_s2_q & ~a_prev_q;
    presc_hit = (presc_q == div);
    mode_chg  = (mode != mode_q);
    step      = enable & ~mode_chg & (edge_sel ? a_rise : presc_hit);

    presc_d = presc_q + DIV_W'(1);
    if (!enable || edge_sel || mode_chg || presc_hit) begin
      presc_d = '0;
    end

    pat_d = pat_q;
    if (mode_chg) begin
      pat_d = seed;
    end else if (step) begin
      pat_d = pat_next;
    end

    tick_d = step;
    wrap_d = step & (pat_next == seed);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_s1_q   <= 1'b0;
      a_s2_q   <= 1'b0;
      a_prev_q <= 1'b0;
      b_s1_q   <= 1'b0;
      b_s2_q   <= 1'b0;
      lo_q     <= 4'b0000;
      presc_q  <= '0;
      pat_q    <= seed;
      mode_q   <= mode;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      a_s1_q   <= ain;
      a_s2_q   <= a_s1_q;
      a_prev_q <= a_s2_q;
      b_s1_q   <= bin;
      b_s2_q   <= b_s1_q;
      lo_q     <= {a_s2_q | b_s2_q, a_s2_q ^ b_s2_q, a_s2_q, b_s2_q};
      presc_q  <= presc_d;
      pat_q    <= pat_d;
      mode_q   <= mode;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
    end
  end

  assign logic_out = lo_q;
  assign pattern   = pat_q;
  assign tick      = tick_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Self-checking bench for test_pattern_gen (WIDTH=8): vector table, directed sequences and a
// randomized run against a step-index reference model.
module tb_test_pattern_gen;
  logic        clk = 1'b0;
  logic        rst_n, ain, bin, enable, edge_sel;
  logic [1:0]  mode;
  logic [15:0] div;
  logic [3:0]  logic_out;
  logic [7:0]  pattern;
  logic        tick, wrap;

  always #5 clk = ~clk;

  test_pattern_gen #(.WIDTH(8), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ain(ain), .bin(bin), .enable(enable), .mode(mode),
    .edge_sel(edge_sel), .div(div), .logic_out(logic_out), .pattern(pattern),
    .tick(tick), .wrap(wrap)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pattern is a function of (mode, step index k).
  logic [7:0] lfsr_tab [255];
  bit         ah[$], bh[$];
  int         m_k, m_presc;
  bit         m_tick, m_wrap;
  logic [1:0] m_md;
  logic [3:0] m_lo;
  bit         do_cmp = 1'b0;

  function automatic int period(input logic [1:0] md);
    case (md)
      2'b01:   return 8;
      2'b10:   return 16;
`ifdef TEST_PATTERN_LFSR_EN
      2'b11:   return 255;
`endif
      default: return 256;
    endcase
  endfunction

  function automatic logic [7:0] pat_of(input logic [1:0] md, input int k);
    case (md)
      2'b01:   return 8'(1 << k);
      2'b10:   return (k < 8) ? 8'((1 << k) - 1) : 8'(256 - (1 << (k - 8)));
`ifdef TEST_PATTERN_LFSR_EN
      2'b11:   return lfsr_tab[k];
`endif
      default: return 8'(k);
    endcase
  endfunction

  task automatic step_clk();
    if (!rst_n) begin
      ah = '{0, 0, 0};
      bh = '{0, 0, 0};
      m_k = 0; m_presc = 0; m_tick = 0; m_wrap = 0; m_lo = 4'b0000; m_md = mode;
    end else begin
      bit rise;
      bit st;
      rise = ah[1] && !ah[2];
      m_lo = {ah[1] | bh[1], ah[1] ^ bh[1], ah[1], bh[1]};
      ah.push_front(ain); void'(ah.pop_back());
      bh.push_front(bin); void'(bh.pop_back());
      if (mode != m_md) begin
        m_k = 0; m_presc = 0; m_tick = 0; m_wrap = 0;
      end else begin
        st = enable && (edge_sel ? rise : (m_presc == int'(div)));
        m_presc = (!enable || edge_sel || m_presc == int'(div)) ? 0 : m_presc + 1;
        if (st) m_k = (m_k + 1) % period(mode);
        m_tick = st;
        m_wrap = st && (m_k == 0);
      end
      m_md = mode;
    end
    @(posedge clk);
    #1;
    if (do_cmp) begin
      chk("rnd_pattern", 32'(pattern), 32'(pat_of(m_md, m_k)));
      chk("rnd_tick", 32'(tick), 32'(m_tick));
      chk("rnd_wrap", 32'(wrap), 32'(m_wrap));
      chk("rnd_logic_out", 32'(logic_out), 32'(m_lo));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step_clk();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         a;
    bit         b;
    logic [1:0] md;
    logic [3:0] exp_lo;
    logic [7:0] exp_seed;
  } vec_t;

  vec_t vt[6];

  initial begin
    int n_tick, n_wrap, first_ret, zeros;
    logic [7:0] p, exp_hold;

    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      lfsr_tab[i] = p;
      p = {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
    end

    vt[0] = '{a: 0, b: 0, md: 2'b00, exp_lo: 4'b0000, exp_seed: 8'h00};
    vt[1] = '{a: 1, b: 0, md: 2'b01, exp_lo: 4'b1110, exp_seed: 8'h01};
    vt[2] = '{a: 0, b: 1, md: 2'b10, exp_lo: 4'b1101, exp_seed: 8'h00};
`ifdef TEST_PATTERN_LFSR_EN
    vt[3] = '{a: 1, b: 1, md: 2'b11, exp_lo: 4'b1011, exp_seed: 8'h01};
`else
    vt[3] = '{a: 1, b: 1, md: 2'b11, exp_lo: 4'b1011, exp_seed: 8'h00};
`endif
    vt[4] = '{a: 0, b: 0, md: 2'b01, exp_lo: 4'b0000, exp_seed: 8'h01};
    vt[5] = '{a: 1, b: 0, md: 2'b10, exp_lo: 4'b1110, exp_seed: 8'h00};

    rst_n = 1'b0; ain = 0; bin = 0; enable = 0; edge_sel = 0; mode = 2'b00; div = 16'd0;

    // Reset values, seeds and synchroniser latency.
    foreach (vt[i]) begin
      ain = vt[i].a; bin = vt[i].b; mode = vt[i].md; enable = 1'b0;
      do_reset();
      chk("vec_seed", 32'(pattern), 32'(vt[i].exp_seed));
      chk("vec_reset_lo", 32'(logic_out), 32'h0);
      chk("vec_reset_tick", 32'(tick), 32'h0);
      step_clk(); step_clk();
      chk("vec_lo_early", 32'(logic_out), 32'h0);
      step_clk();
      chk("vec_lo", 32'(logic_out), 32'(vt[i].exp_lo));
    end

    // Count, div=0: full 256-step cycle with a single wrap at 255->0.
    ain = 0; bin = 0; mode = 2'b00; div = 16'd0; enable = 1'b1; edge_sel = 1'b0;
    do_reset();
    n_wrap = 0;
    for (int i = 0; i < 256; i++) begin
      step_clk();
      chk("cnt_pattern", 32'(pattern), 32'((i + 1) % 256));
      chk("cnt_tick", 32'(tick), 32'h1);
      if (wrap) n_wrap++;
      if (i == 255) chk("cnt_wrap_pos", 32'(wrap), 32'h1);
    end
    chk("cnt_wrap_count", 32'(n_wrap), 32'd1);

    // Walking-one, div=3: one step every 4 cycles.
    mode = 2'b01; div = 16'd3;
    do_reset();
    n_tick = 0; n_wrap = 0;
    for (int i = 1; i <= 36; i++) begin
      step_clk();
      if (tick) n_tick++;
      if (wrap) n_wrap++;
      if (i == 3) chk("walk_pre_step", 32'(pattern), 32'h01);
      if (i == 4) chk("walk_first_step", 32'(pattern), 32'h02);
      if (i == 32) chk("walk_wrap", 32'(wrap), 32'h1);
    end
    chk("walk_ticks", 32'(n_tick), 32'd9);
    chk("walk_wraps", 32'(n_wrap), 32'd1);
    chk("walk_final", 32'(pattern), 32'h02);

    // Johnson, div=0: 16-step cycle.
    mode = 2'b10; div = 16'd0;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step_clk();
      chk("john_pattern", 32'(pattern), 32'(pat_of(2'b10, i % 16)));
      chk("john_wrap", 32'(wrap), 32'(i == 16));
    end

    // Edge-triggered stepping: 5 ain pulses, prescaler ignored.
    mode = 2'b00; div = 16'd0; edge_sel = 1'b1;
    do_reset();
    n_tick = 0;
    for (int i = 0; i < 44; i++) begin
      ain = (i < 40) && ((i % 8) < 4);
      step_clk();
      if (tick) n_tick++;
    end
    chk("edge_pattern", 32'(pattern), 32'd5);
    chk("edge_ticks", 32'(n_tick), 32'd5);
    ain = 1; bin = 0;
    step_clk(); step_clk(); step_clk();
    chk("edge_logic_out", 32'(logic_out), 32'b1110);
    ain = 0; edge_sel = 1'b0;

`ifdef TEST_PATTERN_LFSR_EN
    // LFSR period 255, never zero.
    mode = 2'b11; div = 16'd0;
    do_reset();
    first_ret = 0; zeros = 0;
    for (int i = 1; i <= 255; i++) begin
      step_clk();
      if (pattern == 8'h00) zeros++;
      if (pattern == 8'h01 && first_ret == 0) first_ret = i;
    end
    chk("lfsr_period", 32'(first_ret), 32'd255);
    chk("lfsr_zero", 32'(zeros), 32'd0);
`endif

    // Mode 11 run for 10 steps, then enable dropped: hold, no tick.
    mode = 2'b11; div = 16'd0;
    do_reset();
    for (int i = 0; i < 10; i++) step_clk();
    exp_hold = pat_of(2'b11, 10);
    chk("m3_ten_steps", 32'(pattern), 32'(exp_hold));
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_clk();
      chk("hold_pattern", 32'(pattern), 32'(exp_hold));
      chk("hold_tick", 32'(tick), 32'h0);
    end
    enable = 1'b1;
    step_clk();
    chk("resume_pattern", 32'(pattern), 32'(pat_of(2'b11, 11)));

    // Mode change at 0x37 and reset mid-count.
    mode = 2'b00; div = 16'd0;
    do_reset();
    for (int i = 0; i < 55; i++) step_clk();
    chk("pre_mchg", 32'(pattern), 32'h37);
    mode = 2'b01;
    step_clk();
    chk("mchg_pattern", 32'(pattern), 32'h01);
    chk("mchg_tick", 32'(tick), 32'h0);
    chk("mchg_wrap", 32'(wrap), 32'h0);
    mode = 2'b00;
    step_clk();
    for (int i = 0; i < 5; i++) step_clk();
    chk("pre_rst_count", 32'(pattern), 32'h05);
    rst_n = 1'b0;
    step_clk();
    chk("rst_pattern", 32'(pattern), 32'h00);
    chk("rst_tick", 32'(tick), 32'h0);
    rst_n = 1'b1;
    step_clk();
    chk("post_rst_pattern", 32'(pattern), 32'h01);
    chk("post_rst_tick", 32'(tick), 32'h1);

    // Randomized run against the reference model.
    mode = 2'b00; div = 16'd1; enable = 1'b1; edge_sel = 1'b0;
    do_reset();
    do_cmp = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0) mode = 2'($urandom);
      enable = ($urandom_range(7) != 0);
      if ($urandom_range(99) == 0) edge_sel = ~edge_sel;
      if ($urandom_range(49) == 0) div = 16'($urandom_range(3));
      if ($urandom_range(2) == 0) ain = ~ain;
      bin = 1'($urandom);
      rst_n = ($urandom_range(499) != 0);
      step_clk();
    end
    do_cmp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
